eth_log_arbiter: RTL and testbench

// Merges the per-loop log streams (one per eth_frame_loop, C_AXIS_LOG_WIDTH each)

---
 rtl/eth_log_arbiter.sv | 121 ++++++++++++
 tb/tb_eth_log_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_log_arbiter.sv
// eth_log_arbiter: merges the per-loop log streams into one AXI4-Stream.
// Arbitration is packet-level round-robin. Once an input is granted it keeps
// the output until its tlast beat is accepted. A registered output stage keeps
// throughput at one beat per cycle, and each input has a 32-bit packet counter.
//
// state  | meaning
// S_IDLE | no owner; grant the next valid input after rr_ptr when enable=1
// S_BUSY | input sel owns the output until its tlast beat is accepted
module eth_log_arbiter #(
  parameter int  C_AXIS_LOG_WIDTH = 64,
  parameter int  C_NUM_INPUTS     = 2,
  localparam int C_ID_WIDTH       = $clog2(C_NUM_INPUTS)
) (
  input  logic                                     clk,
  input  logic                                     srst,
  input  logic                                     enable,
  input  logic [C_AXIS_LOG_WIDTH*C_NUM_INPUTS-1:0] s_axis_log_tdata,
  input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tlast,
  input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tvalid,
  output logic [C_NUM_INPUTS-1:0]                  s_axis_log_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0]              m_axis_log_tdata,
  output logic [C_ID_WIDTH-1:0]                    m_axis_log_tid,
  output logic                                     m_axis_log_tlast,
  output logic                                     m_axis_log_tvalid,
  input  logic                                     m_axis_log_tready,
  output logic [32*C_NUM_INPUTS-1:0]               frame_count,
  output logic                                     busy
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [C_ID_WIDTH-1:0]       sel, sel_nxt, rr_ptr;
  logic [C_AXIS_LOG_WIDTH-1:0] in_data [C_NUM_INPUTS];
  logic [31:0]                 fc [C_NUM_INPUTS];
  logic                        out_free, beat_acc, pkt_done;

  for (genvar i = 0; i < C_NUM_INPUTS; i++) begin : g_lane
    assign in_data[i]              = s_axis_log_tdata[C_AXIS_LOG_WIDTH*i +: C_AXIS_LOG_WIDTH];
    assign frame_count[32*i +: 32] = fc[i];
  end

  // First requester after ptr, scanning upward with wrap; nearest one wins.
  function automatic logic [C_ID_WIDTH-1:0] rr_pick(input logic [C_ID_WIDTH-1:0] ptr,
                                                    input logic [C_NUM_INPUTS-1:0] req);
    logic [C_ID_WIDTH-1:0] pick;
    logic [C_ID_WIDTH-1:0] idx;
    pick = ptr;
    for (int k = C_NUM_INPUTS; k >= 1; k--) begin
      idx = C_ID_WIDTH'((int'(ptr) + k) % C_NUM_INPUTS);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // The output register can take a beat when empty or being drained this cycle.
  assign out_free = ~m_axis_log_tvalid | m_axis_log_tready;
  assign beat_acc = (state == S_BUSY) & s_axis_log_tvalid[sel] & out_free;
  assign pkt_done = beat_acc & s_axis_log_tlast[sel];
  assign busy     = (state == S_BUSY) | m_axis_log_tvalid;

  // Next-state, grant selection and per-input ready.
  always_comb begin
    state_nxt         = state;
    sel_nxt           = sel;
    s_axis_log_tready = '0;
    case (state)
      S_IDLE: begin
        if (enable && (|s_axis_log_tvalid)) begin
          sel_nxt   = rr_pick(rr_ptr, s_axis_log_tvalid);
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        s_axis_log_tready[sel] = out_free;
        if (pkt_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, grant owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (srst) begin
      state  <= S_IDLE;
      sel    <= '0;
      rr_ptr <= C_ID_WIDTH'(C_NUM_INPUTS - 1);
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (pkt_done) rr_ptr <= sel;
    end
  end

  // Output register: load on accepted beat, otherwise drain on downstream ready.
  always_ff @(posedge clk) begin
    if (srst) begin
      m_axis_log_tvalid <= 1'b0;
      m_axis_log_tdata  <= '0;
      m_axis_log_tlast  <= 1'b0;
      m_axis_log_tid    <= '0;
    end else if (beat_acc) begin
      m_axis_log_tvalid <= 1'b1;
      m_axis_log_tdata  <= in_data[sel];
      m_axis_log_tlast  <= s_axis_log_tlast[sel];
      m_axis_log_tid    <= sel;
    end else if (m_axis_log_tready) begin
      m_axis_log_tvalid <= 1'b0;
    end
  end

  // Per-input packet counters, bumped when a tlast beat is accepted.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < C_NUM_INPUTS; i++) fc[i] <= '0;
    end else if (pkt_done) begin
      fc[sel] <= fc[sel] + 32'd1;
    end
  end

endmodule

// File: tb/tb_eth_log_arbiter.sv
// tb_eth_log_arbiter: directed and randomized scenarios for eth_log_arbiter,
// checked against a packet-level round-robin reference model.
module tb_eth_log_arbiter;

  localparam int W  = 64;
  localparam int NI = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [0:0]   id;
    logic [31:0]  cyc;
  } obeat_t;

  logic            clk = 1'b0;
  logic            srst = 1'b1;
  logic            enable = 1'b1;
  logic [W*NI-1:0] s_tdata = '0;
  logic [NI-1:0]   s_tlast = '0;
  logic [NI-1:0]   s_tvalid = '0;
  logic [NI-1:0]   s_tready;
  logic [W-1:0]    m_tdata;
  logic [0:0]      m_tid;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [32*NI-1:0] frame_count;
  logic            busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] cyc = 0;
  beat_t  q0[$], q1[$];      // beats still to be offered by each source
  beat_t  e0[$], e1[$];      // copies of generated beats for the model
  obeat_t out_q[$];          // beats accepted on the output
  obeat_t exp_q[$];          // model prediction
  logic   inpk0 = 0, inpk1 = 0;
  int     acc0 = 0, acc1 = 0;
  logic [31:0] rise0 = 0, rise1 = 0;
  int     rdy_mode = 0;      // 0: always ready, 1: alternate, 2: random
  int     rdy_pct = 100;
  int     gap_pct = 0;       // chance of a mid-packet tvalid gap

  eth_log_arbiter #(.C_AXIS_LOG_WIDTH(W), .C_NUM_INPUTS(NI)) dut (
    .clk(clk), .srst(srst), .enable(enable),
    .s_axis_log_tdata(s_tdata), .s_axis_log_tlast(s_tlast),
    .s_axis_log_tvalid(s_tvalid), .s_axis_log_tready(s_tready),
    .m_axis_log_tdata(m_tdata), .m_axis_log_tid(m_tid),
    .m_axis_log_tlast(m_tlast), .m_axis_log_tvalid(m_tvalid),
    .m_axis_log_tready(m_tready),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source and sink drivers: sample handshakes at negedge, drive after posedge.
  always begin
    logic f0, f1, v0, v1;
    @(negedge clk);
    f0 = s_tvalid[0] & s_tready[0];
    f1 = s_tvalid[1] & s_tready[1];
    if (m_tvalid && m_tready) out_q.push_back('{m_tdata, m_tlast, m_tid, cyc});
    @(posedge clk);
    #1;
    if (f0) begin
      if (q0.size() > 0) begin inpk0 = !q0[0].last; void'(q0.pop_front()); end
      acc0++;
    end
    if (f1) begin
      if (q1.size() > 0) begin inpk1 = !q1[0].last; void'(q1.pop_front()); end
      acc1++;
    end
    v0 = (q0.size() > 0) && (!inpk0 || ($urandom_range(0, 99) >= gap_pct));
    v1 = (q1.size() > 0) && (!inpk1 || ($urandom_range(0, 99) >= gap_pct));
    if (v0 && !s_tvalid[0]) rise0 = cyc;
    if (v1 && !s_tvalid[1]) rise1 = cyc;
    s_tvalid = {v1, v0};
    s_tdata[0 +: W] = (q0.size() > 0) ? q0[0].data : '0;
    s_tdata[W +: W] = (q1.size() > 0) ? q1[0].data : '0;
    s_tlast = {(q1.size() > 0) ? q1[0].last : 1'b0, (q0.size() > 0) ? q0[0].last : 1'b0};
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 99) < rdy_pct);
    endcase
  end

  task automatic apply_reset();
    @(negedge clk);
    srst = 1'b1;
    enable = 1'b1;
    rdy_mode = 0;
    gap_pct = 0;
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    repeat (2) @(negedge clk);
    out_q.delete();
    inpk0 = 0; inpk1 = 0; acc0 = 0; acc1 = 0;
    srst = 1'b0;
  endtask

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      if (src == 0) begin q0.push_back(b); e0.push_back(b); end
      else          begin q1.push_back(b); e1.push_back(b); end
    end
  endtask

  // Reference: whole packets, next pending input after the last one served.
  function automatic void build_expected();
    int ptr;
    int pick;
    beat_t b;
    exp_q.delete();
    ptr = NI - 1;
    while (e0.size() > 0 || e1.size() > 0) begin
      if (ptr == 0) pick = (e1.size() > 0) ? 1 : 0;
      else          pick = (e0.size() > 0) ? 0 : 1;
      do begin
        b = (pick == 0) ? e0.pop_front() : e1.pop_front();
        exp_q.push_back('{b.data, b.last, 1'(pick), 32'd0});
      end while (!b.last);
      ptr = pick;
    end
  endfunction

  task automatic test_reset();
    srst = 1'b1;
    push_pkt(0, 2);
    repeat (3) @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tdata !== '0 || m_tlast !== 1'b0 || m_tid !== 1'b0) begin errors++; $display("FAIL reset_outregs: got data=%h last=%b id=%b expected zeros", m_tdata, m_tlast, m_tid); end
    checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL reset_tready: got %b expected 00", s_tready); end
    checks++; if (frame_count !== '0) begin errors++; $display("FAIL reset_fc: got %h expected 0", frame_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_packet();
    logic seen_rdy1;
    apply_reset();
    push_pkt(0, 3);
    build_expected();
    seen_rdy1 = 1'b0;
    for (int t = 0; t < 40 && out_q.size() < 3; t++) begin
      @(negedge clk);
      seen_rdy1 |= s_tready[1];
    end
    repeat (4) begin @(negedge clk); seen_rdy1 |= s_tready[1]; end
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].id !== 1'b0 || out_q[i].cyc != rise0 + 2 + i)
        begin errors++; $display("FAIL single_beat[%0d]: got data=%h last=%b id=%b cyc=%0d expected data=%h last=%b id=0 cyc=%0d",
                                 i, out_q[i].data, out_q[i].last, out_q[i].id, out_q[i].cyc, exp_q[i].data, exp_q[i].last, rise0 + 2 + i); end
    end
    checks++; if (seen_rdy1 !== 1'b0) begin errors++; $display("FAIL single_tready1: got %b expected 0", seen_rdy1); end
    checks++; if (frame_count !== {32'd0, 32'd1}) begin errors++; $display("FAIL single_fc: got %h expected %h", frame_count, {32'd0, 32'd1}); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_cyc [4];
    apply_reset();
    push_pkt(0, 2);
    push_pkt(1, 2);
    build_expected();
    for (int t = 0; t < 40 && out_q.size() < 4; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    exp_cyc[0] = rise0 + 2; exp_cyc[1] = rise0 + 3; exp_cyc[2] = rise0 + 5; exp_cyc[3] = rise0 + 6;
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL contend_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].data !== exp_q[i].data || out_q[i].id !== exp_q[i].id || out_q[i].cyc != exp_cyc[i])
        begin errors++; $display("FAIL contend_beat[%0d]: got data=%h id=%b cyc=%0d expected data=%h id=%b cyc=%0d",
                                 i, out_q[i].data, out_q[i].id, out_q[i].cyc, exp_q[i].data, exp_q[i].id, exp_cyc[i]); end
    end
    checks++; if (frame_count !== {32'd1, 32'd1}) begin errors++; $display("FAIL contend_fc: got %h expected %h", frame_count, {32'd1, 32'd1}); end
  endtask

  task automatic test_round_robin();
    int pkt;
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, $urandom_range(1, 4));
      push_pkt(1, $urandom_range(1, 4));
    end
    build_expected();
    for (int t = 0; t < 300 && out_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    pkt = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].id !== exp_q[i].id)
        begin errors++; $display("FAIL rr_beat[%0d]: got data=%h last=%b id=%b expected data=%h last=%b id=%b",
                                 i, out_q[i].data, out_q[i].last, out_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].id); end
      if (out_q[i].last) begin
        checks++;
        if (out_q[i].id !== 1'(pkt % 2)) begin errors++; $display("FAIL rr_alternate[%0d]: got tid %b expected %0d", pkt, out_q[i].id, pkt % 2); end
        pkt++;
      end
    end
    checks++; if (frame_count !== {32'd4, 32'd4}) begin errors++; $display("FAIL rr_fc: got %h expected %h", frame_count, {32'd4, 32'd4}); end
  endtask

  task automatic test_backpressure();
    logic         pv, pr, pl;
    logic [W-1:0] pd;
    logic [0:0]   pid;
    int           bad;
    apply_reset();
    rdy_mode = 1;
    push_pkt(0, 8);
    build_expected();
    pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0; pid = '0; bad = 0;
    for (int t = 0; t < 100 && out_q.size() < 8; t++) begin
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl || m_tid !== pid) begin
          errors++;
          $display("FAIL bp_stable: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b", m_tvalid, m_tdata, m_tlast, pd, pl);
        end
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast; pid = m_tid;
    end
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++)
      if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order: got %0d wrong beats expected 0", bad); end
  endtask

  task automatic test_enable();
    int bad;
    apply_reset();
    push_pkt(0, 5);
    for (int t = 0; t < 40 && acc0 < 2; t++) @(negedge clk);
    enable = 1'b0;
    push_pkt(1, 2);
    build_expected();
    repeat (12) @(negedge clk);
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i].id !== 1'b0 || out_q[i].data !== exp_q[i].data) bad++;
    checks++; if (out_q.size() != 5 || bad != 0) begin errors++; $display("FAIL en_drain: got %0d beats (%0d wrong) expected 5 (0 wrong)", out_q.size(), bad); end
    checks++; if (s_tready[1] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_hold: got tready1=%b busy=%b expected 0 0", s_tready[1], busy); end
    enable = 1'b1;
    checks++; if (s_tready[1] !== 1'b0) begin errors++; $display("FAIL en_grant_early: got tready1=%b expected 0", s_tready[1]); end
    @(negedge clk);
    checks++; if (s_tready[1] !== 1'b1) begin errors++; $display("FAIL en_grant: got tready1=%b expected 1", s_tready[1]); end
    for (int t = 0; t < 40 && out_q.size() < 7; t++) @(negedge clk);
    checks++; if (frame_count !== {32'd1, 32'd1}) begin errors++; $display("FAIL en_fc: got %h expected %h", frame_count, {32'd1, 32'd1}); end
  endtask

  task automatic test_srst_mid_packet();
    apply_reset();
    push_pkt(0, 6);
    for (int t = 0; t < 40 && acc0 < 3; t++) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 2'b00 || frame_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL srst_state: got tvalid=%b tready=%b fc=%h busy=%b expected 0 00 0 0", m_tvalid, s_tready, frame_count, busy);
    end
    q0.delete(); e0.delete(); inpk0 = 0;
    push_pkt(0, 1);
    push_pkt(1, 1);
    @(negedge clk);
    out_q.delete();
    srst = 1'b0;
    for (int t = 0; t < 40 && out_q.size() < 2; t++) @(negedge clk);
    checks++;
    if (out_q.size() < 2 || out_q[0].id !== 1'b0 || out_q[1].id !== 1'b1) begin
      errors++;
      $display("FAIL srst_winner: got %0d beats first id=%b expected 2 beats ids 0,1", out_q.size(), (out_q.size() > 0) ? out_q[0].id : 1'bx);
    end
    checks++; if (frame_count !== {32'd1, 32'd1}) begin errors++; $display("FAIL srst_fc: got %h expected %h", frame_count, {32'd1, 32'd1}); end
  endtask

  task automatic test_random_traffic();
    int np;
    int bad;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      np = $urandom_range(3, 6);
      for (int p = 0; p < np; p++) begin
        push_pkt(0, $urandom_range(1, 6));
        push_pkt(1, $urandom_range(1, 6));
      end
      build_expected();
      gap_pct = 30;
      rdy_pct = 60;
      rdy_mode = 2;
      for (int t = 0; t < 2000 && out_q.size() < exp_q.size(); t++) @(negedge clk);
      rdy_mode = 0;
      repeat (4) @(negedge clk);
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
        if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].id !== exp_q[i].id) bad++;
      checks++;
      if (out_q.size() != exp_q.size() || bad != 0) begin
        errors++;
        $display("FAIL rand_stream[%0d]: got %0d beats (%0d wrong) expected %0d beats", r, out_q.size(), bad, exp_q.size());
      end
      checks++;
      if (frame_count !== {32'(np), 32'(np)}) begin errors++; $display("FAIL rand_fc[%0d]: got %h expected %h", r, frame_count, {32'(np), 32'(np)}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_srst_mid_packet();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
